seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Iterative unsigned restoring divider; one quotient bit per clock.
- Built on the team's subtract/compare, counter and register primitives.
- Sits upstream of result-consuming datapath stages; accepts an operand pair on a start pulse and returns quotient and remainder with a one-cycle done pulse.
- Operands and results are registered; outputs stay stable between operations.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  dividend, captured on accepted start
divisor  input  WIDTH  divisor, captured on accepted start
busy  output  1  high from the cycle after an accepted start until done deasserts
done  output  1  one-cycle pulse; quotient/remainder valid
div_by_zero  output  1  set with done when captured divisor == 0; held until next accepted start
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: state IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0.
- rst has priority over all other inputs, including mid-operation; the operation is aborted and no done is issued.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0, divisor!=0:
  - capture operands: Q <= dividend, R (WIDTH+1 bits) <= 0, D <= divisor, counter <= 0;
  - clear div_by_zero; go to CALC.
- IDLE, start=1 at edge E0, divisor==0:
  - quotient <= all ones, remainder <= dividend, div_by_zero <= 1;
  - go to DONE. done is high in the cycle after E0.
- CALC, each edge:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}; Q <= Q << 1.
  - If S >= D (unsigned, WIDTH+1-bit compare): R <= S - D, Q[0] <= 1; else R <= S, Q[0] <= 0.
  - counter <= counter + 1.
- CALC exit: after exactly WIDTH iterations (edges E1..E_WIDTH):
  - quotient <= Q, remainder <= R[WIDTH-1:0];
  - go to DONE. done is high in the cycle after edge E_WIDTH (latency WIDTH+1 edges from start).
- DONE: done=1 for exactly one cycle; next edge goes to IDLE. busy=1 in CALC and DONE.
- start in CALC or DONE is ignored; no queuing. A new start is accepted earliest at the edge after done's cycle.
- quotient, remainder and div_by_zero hold their values in IDLE until the next accepted start.
- Invariant: dividend == quotient*divisor + remainder, with remainder < divisor, for all divisor != 0.
- Operands are sampled only at the accepting edge; input changes during CALC have no effect.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are captured at start, and signs are recorded.
  - Sign fix-up is applied combinationally when results are loaded at CALC exit, so latency is unchanged.
  - Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones (-1), remainder = dividend.
  - -2^(WIDTH-1) / -1 yields quotient = -2^(WIDTH-1) (wraps), remainder = 0.
- Undefined: purely unsigned; no sign logic is synthesized.

Test Plan:
- Reset and idle: WIDTH=8, rst high 2 cycles, start=0 -> all outputs 0; busy=0.
- Normal divide: start with 100/7 -> done exactly 9 edges after start, quotient=14, remainder=2, div_by_zero=0; outputs hold afterwards.
- Edge values: 5/9 -> q=0, r=5; 255/1 -> q=255, r=0; 255/255 -> q=1, r=0; each with 9-edge latency.
- Divide by zero: 77/0 -> done in the cycle after the start edge, q=255, r=77, div_by_zero=1; the next start with 10/3 clears the flag (q=3, r=1).
- Handshake and abort:
  - start re-pulsed with 9/2 during CALC of 200/3 -> ignored; result q=66, r=2.
  - rst asserted mid-CALC -> IDLE, no done, outputs 0.
  - start held high continuously -> back-to-back operations, each producing a single done pulse.
- DIV_SIGNED_EN: -100/7 -> q=0xF2 (-14), r=0xFE (-2); 100/-7 -> q=-14, r=2; -128/-1 -> q=0x80, r=0.

Source files
------------

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, WIDTH+1 edges from start to done.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is purely unsigned.

module seq_divider_sub_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         ge
);

  logic [W:0] ext;

  // The borrow out of a zero-extended subtraction doubles as the a >= b flag.
  assign ext  = {1'b0, a} - {1'b0, b};
  assign diff = ext[W-1:0];
  assign ge   = ~ext[W];

endmodule

module seq_divider_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

module seq_divider_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

module seq_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             accept;
  logic             zero_div;
  logic             accept_calc;
  logic             accept_zero;
  logic             in_calc;
  logic             last_iter;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] d_work;
  logic [WIDTH-1:0] q_load;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] s_lo;
  logic [WIDTH-1:0] s_diff;
  logic             s_msb;
  logic             s_ge_lo;
  logic             take;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic             results_load;

  assign zero_div    = (divisor == '0);
  assign accept      = (state == IDLE) && start;
  assign accept_calc = accept && !zero_div;
  assign accept_zero = accept && zero_div;
  assign in_calc     = (state == CALC);
  assign last_iter   = in_calc && (count == CNT_W'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
  logic neg_q;
  logic neg_r;

  assign dvd_neg = dividend[WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
  // The most negative value maps onto itself, which is exactly its unsigned magnitude.
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor  : divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept_calc) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end

  assign q_fix = neg_q ? -q_step : q_step;
  assign r_fix = neg_r ? -r_step : r_step;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_fix   = q_step;
  assign r_fix   = r_step;
`endif

  // S = {R, Q[msb]} is WIDTH+1 bits; a set top bit already guarantees S >= D, and the
  // low WIDTH bits of S - D are then exact, so the partial remainder needs only WIDTH bits.
  assign s_msb = r_work[WIDTH-1];
  assign s_lo  = {r_work[WIDTH-2:0], q_work[WIDTH-1]};

  seq_divider_sub_cmp #(.W(WIDTH)) u_sub_cmp (
    .a    (s_lo),
    .b    (d_work),
    .diff (s_diff),
    .ge   (s_ge_lo)
  );

  assign take   = s_msb | s_ge_lo;
  assign r_step = take ? s_diff : s_lo;
  assign q_step = {q_work[WIDTH-2:0], take};
  assign q_load = accept_calc ? dvd_mag : q_step;

  seq_divider_reg #(.W(WIDTH)) u_q_work (
    .clk  (clk),
    .rst  (rst),
    .load (accept_calc || in_calc),
    .d    (q_load),
    .q    (q_work)
  );

  seq_divider_reg #(.W(WIDTH)) u_r_work (
    .clk  (clk),
    .rst  (rst),
    .load (accept_calc || in_calc),
    .d    (accept_calc ? '0 : r_step),
    .q    (r_work)
  );

  seq_divider_reg #(.W(WIDTH)) u_d_work (
    .clk  (clk),
    .rst  (rst),
    .load (accept_calc),
    .d    (dvs_mag),
    .q    (d_work)
  );

  seq_divider_counter #(.W(CNT_W)) u_count (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept_calc),
    .en    (in_calc),
    .count (count)
  );

  // Results are loaded either straight from the zero-divisor shortcut or from the final iteration.
  assign results_load = accept_zero || last_iter;
  assign quotient_d   = accept_zero ? '1       : q_fix;
  assign remainder_d  = accept_zero ? dividend : r_fix;

  seq_divider_reg #(.W(WIDTH)) u_quotient (
    .clk  (clk),
    .rst  (rst),
    .load (results_load),
    .d    (quotient_d),
    .q    (quotient)
  );

  seq_divider_reg #(.W(WIDTH)) u_remainder (
    .clk  (clk),
    .rst  (rst),
    .load (results_load),
    .d    (remainder_d),
    .q    (remainder)
  );

  seq_divider_reg #(.W(1)) u_div_by_zero (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .d    (zero_div),
    .q    (div_by_zero)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = zero_div ? DONE_ST : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE_ST;
        end
      end
      DONE_ST: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE_ST);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against an arithmetic model.
// Compile with DIV_SIGNED_EN defined to exercise the two's-complement build.

module tb_seq_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the quotient/remainder definition in plain integer arithmetic.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef DIV_SIGNED_EN
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    int ia;
    int ib;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = a;
      sb = b;
      ia = sa;
      ib = sb;
      q  = W'(ia / ib);
      r  = W'(ia % ib);
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // One operation: start at an edge, scramble inputs during CALC, measure latency, check results.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input bit repulse);
    int lat;
    int exp_lat;
    exp_lat = (b == '0) ? 1 : W + 1;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      if (repulse && lat == 3) begin
        start    = 1'b1;
        dividend = W'(9);
        divisor  = W'(2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, (b == '0));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_q_hold"}, quotient, eq);
    check({tag, "_r_hold"}, remainder, er);
  endtask

  task automatic run_rand(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    ref_div(a, b, eq, er);
    run_op(tag, a, b, eq, er, 1'b0);
  endtask

  initial begin
    int pulses;
    int prev_done;
    int long_pulse;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    rst = 1'b0;

`ifdef DIV_SIGNED_EN
    run_op("s_neg_dvd", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0);
    run_op("s_neg_dvs", 8'd100, 8'hF9, 8'hF2, 8'd2, 1'b0);
    run_op("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
    run_op("s_div0", 8'hB3, 8'd0, 8'hFF, 8'hB3, 1'b0);
    run_op("s_after0", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
    run_op("s_repulse", 8'd100, 8'd3, 8'd33, 8'd1, 1'b1);
`else
    run_op("u_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run_op("u_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run_op("u_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_op("u_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_op("u_div0", 8'd77, 8'd0, 8'd255, 8'd77, 1'b0);
    run_op("u_after0", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
    run_op("u_repulse", 8'd200, 8'd3, 8'd66, 8'd2, 1'b1);
`endif

    // Abort mid-CALC: reset wins, no done follows.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_q", quotient, '0);
    check("abort_r", remainder, '0);
    check("abort_dbz", div_by_zero, 1'b0);
    pulses = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Start held high: back-to-back operations, one done pulse each (period W+2 edges).
    @(negedge clk);
    dividend   = 8'd50;
    divisor    = 8'd6;
    start      = 1'b1;
    pulses     = 0;
    prev_done  = 0;
    long_pulse = 0;
    repeat (3 * (W + 2)) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (prev_done != 0) long_pulse++;
        check("held_q", quotient, 8'd8);
        check("held_r", remainder, 8'd2);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("held_pulses", pulses, 3);
    check("held_single", long_pulse, 0);
    repeat (W + 4) @(posedge clk);
    #1;
    check("held_idle", busy, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_rand($sformatf("rand%0d", i), ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
